// File: rtl/pipeline_pkg.sv
// Shared definitions for the 5-stage pipeline: control bundle layout, bubble value, stage FSM states.
package pipeline_pkg;

    localparam int unsigned CTRL_W = 9;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CNT3_W = 3;

    // Control bundle bit positions, LSB first
    localparam int unsigned CTRL_REG_WRITE  = 0;
    localparam int unsigned CTRL_MEM_TO_REG = 1;
    localparam int unsigned CTRL_MEM_READ   = 2;
    localparam int unsigned CTRL_MEM_WRITE  = 3;
    localparam int unsigned CTRL_ALU_SRC    = 4;
    localparam int unsigned CTRL_REG_DST    = 5;
    localparam int unsigned CTRL_ALU_OP_LSB = 6;
    localparam int unsigned CTRL_ALU_OP_MSB = 8;

    // All-zero control bundle: nothing written, nothing accessed
    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } stage_state_t;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard equation: a load in EX whose destination is a source of the instruction in ID.
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic             mem_read_ex,
    input  logic             reg_write_ex,
    input  logic [REG_W-1:0] rt_ex,
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    input  logic             uses_rt_id,
    output logic             hazard
);

    // r0 is hardwired zero, so a load targeting it never creates a dependency
    always_comb begin
        hazard = mem_read_ex & reg_write_ex & (rt_ex != '0)
               & ((rt_ex == rs_id) | (uses_rt_id & (rt_ex == rt_id)));
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall FSM, branch flush and saturating stall counter.
module id_ex_stage #(
    parameter int unsigned DATA_W            = 32,
    parameter int unsigned CTRL_W            = pipeline_pkg::CTRL_W,
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned CNT_W             = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [CTRL_W-1:0] ctrl_id,
    input  logic              uses_rt_id,
    input  logic [4:0]        rs_id,
    input  logic [4:0]        rt_id,
    input  logic [4:0]        rd_id,
    input  logic [DATA_W-1:0] pc_plus4_id,
    input  logic [DATA_W-1:0] rd1_id,
    input  logic [DATA_W-1:0] rd2_id,
    input  logic [DATA_W-1:0] imm_id,
    output logic [CTRL_W-1:0] ctrl_ex,
    output logic [4:0]        rs_ex,
    output logic [4:0]        rt_ex,
    output logic [4:0]        rd_ex,
    output logic [DATA_W-1:0] pc_plus4_ex,
    output logic [DATA_W-1:0] rd1_ex,
    output logic [DATA_W-1:0] rd2_ex,
    output logic [DATA_W-1:0] imm_ex,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count
);

    import pipeline_pkg::*;

    stage_state_t      state_q;
    stage_state_t      state_d;
    logic [CNT3_W-1:0] cnt_q;
    logic [CNT3_W-1:0] cnt_d;
    logic              hazard;
    logic              load_bubble;
    logic              count_inc;

    hazard_detect u_hazard_detect (
        .mem_read_ex  (ctrl_ex[CTRL_MEM_READ]),
        .reg_write_ex (ctrl_ex[CTRL_REG_WRITE]),
        .rt_ex        (rt_ex),
        .rs_id        (rs_id),
        .rt_id        (rt_id),
        .uses_rt_id   (uses_rt_id),
        .hazard       (hazard)
    );

    // Next-state and stall control; flush overrides both hazard and an ongoing stall
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_bubble = 1'b0;
        count_inc   = 1'b0;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        stall       = 1'b0;

        if (flush) begin
            load_bubble = 1'b1;
            state_d     = IDLE;
            cnt_d       = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hazard) begin
                        stall       = 1'b1;
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        load_bubble = 1'b1;
                        count_inc   = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = STALL;
                            cnt_d   = CNT3_W'(LOAD_STALL_CYCLES - 1);
                        end
                    end
                end
                STALL: begin
                    // EX holds a bubble here, so the hazard cannot be live
                    stall       = 1'b1;
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    load_bubble = 1'b1;
                    count_inc   = 1'b1;
                    cnt_d       = cnt_q - CNT3_W'(1);
                    if (cnt_q == CNT3_W'(1)) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // FSM state and bubble down-counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stage register: ID values, or an all-zero bubble when stalling or flushing
    always_ff @(posedge clk) begin
        if (reset || load_bubble) begin
            ctrl_ex     <= CTRL_NOP;
            rs_ex       <= '0;
            rt_ex       <= '0;
            rd_ex       <= '0;
            pc_plus4_ex <= '0;
            rd1_ex      <= '0;
            rd2_ex      <= '0;
            imm_ex      <= '0;
        end else begin
            ctrl_ex     <= ctrl_id;
            rs_ex       <= rs_id;
            rt_ex       <= rt_id;
            rd_ex       <= rd_id;
            pc_plus4_ex <= pc_plus4_id;
            rd1_ex      <= rd1_id;
            rd2_ex      <= rd2_id;
            imm_ex      <= imm_id;
        end
    end

    // Hazard bubble counter, sticks at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (count_inc && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: three parameterisations share one stimulus stream and a behavioural model.
module tb_id_ex_stage;

    localparam int NI = 3;
    // instance 0: defaults, instance 1: 3-cycle load stall, instance 2: 4-bit counter
    localparam int N_BUB [NI] = '{1, 3, 1};
    localparam int C_MAX [NI] = '{65535, 65535, 15};

    logic        clk;
    logic        reset;
    logic        flush;
    logic [8:0]  ctrl_id;
    logic        uses_rt_id;
    logic [4:0]  rs_id, rt_id, rd_id;
    logic [31:0] pc_plus4_id, rd1_id, rd2_id, imm_id;

    logic [8:0]  a_ctrl [NI];
    logic [4:0]  a_rs [NI], a_rt [NI], a_rd [NI];
    logic [31:0] a_pc [NI], a_rd1 [NI], a_rd2 [NI], a_imm [NI];
    logic        a_pcw [NI], a_ifw [NI], a_stall [NI];
    logic [15:0] a_cnt [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned CW = (g == 2) ? 4 : 16;
        logic [CW-1:0] sc;
        id_ex_stage #(
            .DATA_W            (32),
            .CTRL_W            (9),
            .LOAD_STALL_CYCLES ((g == 1) ? 3 : 1),
            .CNT_W             (CW)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .flush       (flush),
            .ctrl_id     (ctrl_id),
            .uses_rt_id  (uses_rt_id),
            .rs_id       (rs_id),
            .rt_id       (rt_id),
            .rd_id       (rd_id),
            .pc_plus4_id (pc_plus4_id),
            .rd1_id      (rd1_id),
            .rd2_id      (rd2_id),
            .imm_id      (imm_id),
            .ctrl_ex     (a_ctrl[g]),
            .rs_ex       (a_rs[g]),
            .rt_ex       (a_rt[g]),
            .rd_ex       (a_rd[g]),
            .pc_plus4_ex (a_pc[g]),
            .rd1_ex      (a_rd1[g]),
            .rd2_ex      (a_rd2[g]),
            .imm_ex      (a_imm[g]),
            .pc_write    (a_pcw[g]),
            .if_id_write (a_ifw[g]),
            .stall       (a_stall[g]),
            .stall_count (sc)
        );
        assign a_cnt[g] = 16'(sc);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Behavioural model: EX register contents, bubbles still owed, bubble total
    logic [8:0]  m_ctrl [NI] = '{default: '0};
    logic [4:0]  m_rs [NI] = '{default: '0}, m_rt [NI] = '{default: '0}, m_rd [NI] = '{default: '0};
    logic [31:0] m_pc [NI] = '{default: '0}, m_rd1 [NI] = '{default: '0};
    logic [31:0] m_rd2 [NI] = '{default: '0}, m_imm [NI] = '{default: '0};
    int          m_owed [NI] = '{default: 0};
    int          m_cnt [NI] = '{default: 0};

    // Load in EX (mem_read bit 2, reg_write bit 0) whose rt is read by the ID instruction
    function automatic bit model_hazard(input int k);
        bit is_load = m_ctrl[k][2] && m_ctrl[k][0];
        bit dep = (m_rt[k] == rs_id) || (uses_rt_id && m_rt[k] == rt_id);
        return is_load && (m_rt[k] != 0) && dep;
    endfunction

    function automatic bit model_stall(input int k);
        if (flush) return 1'b0;
        if (m_owed[k] > 0) return 1'b1;
        return model_hazard(k);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            bit bubble;
            bit inc;
            bubble = 1'b0;
            inc = 1'b0;
            if (reset) begin
                bubble = 1'b1;
                m_owed[k] = 0;
                m_cnt[k] = 0;
            end else if (flush) begin
                bubble = 1'b1;
                m_owed[k] = 0;
            end else if (m_owed[k] > 0) begin
                bubble = 1'b1;
                inc = 1'b1;
                m_owed[k] = m_owed[k] - 1;
            end else if (model_hazard(k)) begin
                bubble = 1'b1;
                inc = 1'b1;
                m_owed[k] = N_BUB[k] - 1;
            end
            if (inc && m_cnt[k] < C_MAX[k]) m_cnt[k] = m_cnt[k] + 1;
            if (bubble) begin
                m_ctrl[k] = '0; m_rs[k] = '0; m_rt[k] = '0; m_rd[k] = '0;
                m_pc[k] = '0; m_rd1[k] = '0; m_rd2[k] = '0; m_imm[k] = '0;
            end else begin
                m_ctrl[k] = ctrl_id; m_rs[k] = rs_id; m_rt[k] = rt_id; m_rd[k] = rd_id;
                m_pc[k] = pc_plus4_id; m_rd1[k] = rd1_id; m_rd2[k] = rd2_id; m_imm[k] = imm_id;
            end
        end
    end

    // Every-cycle comparison against the model, mid-cycle
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NI; k++) begin
                bit s;
                s = model_stall(k);
                chk($sformatf("i%0d_ctrl_ex", k), 32'(a_ctrl[k]), 32'(m_ctrl[k]));
                chk($sformatf("i%0d_rs_ex", k), 32'(a_rs[k]), 32'(m_rs[k]));
                chk($sformatf("i%0d_rt_ex", k), 32'(a_rt[k]), 32'(m_rt[k]));
                chk($sformatf("i%0d_rd_ex", k), 32'(a_rd[k]), 32'(m_rd[k]));
                chk($sformatf("i%0d_pc_plus4_ex", k), a_pc[k], m_pc[k]);
                chk($sformatf("i%0d_rd1_ex", k), a_rd1[k], m_rd1[k]);
                chk($sformatf("i%0d_rd2_ex", k), a_rd2[k], m_rd2[k]);
                chk($sformatf("i%0d_imm_ex", k), a_imm[k], m_imm[k]);
                chk($sformatf("i%0d_stall", k), 32'(a_stall[k]), 32'(s));
                chk($sformatf("i%0d_pc_write", k), 32'(a_pcw[k]), 32'(!s));
                chk($sformatf("i%0d_if_id_write", k), 32'(a_ifw[k]), 32'(!s));
                chk($sformatf("i%0d_stall_count", k), 32'(a_cnt[k]), 32'(m_cnt[k]));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [8:0] c, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic urt, input logic [31:0] d1);
        ctrl_id     = c;
        rs_id       = rs;
        rt_id       = rt;
        rd_id       = rd;
        uses_rt_id  = urt;
        rd1_id      = d1;
        pc_plus4_id = d1 + 32'd4;
        rd2_id      = ~d1;
        imm_id      = d1 << 4;
    endtask

    task automatic nops(input int n);
        set_id(9'h000, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
        repeat (n) cyc();
    endtask

    localparam logic [8:0] LW  = 9'h017;
    localparam logic [8:0] ALU = 9'h041;

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        set_id(9'h000, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
        @(posedge clk);
        chk_en = 1'b1;
        #1;
        cyc();
        chk("reset_ctrl_ex", 32'(a_ctrl[0]), 32'h0);
        chk("reset_pc_write", 32'(a_pcw[0]), 32'h1);
        chk("reset_stall_count", 32'(a_cnt[0]), 32'h0);
        reset = 1'b0;

        // Plain pass-through
        set_id(ALU, 5'd3, 5'd4, 5'd5, 1'b1, 32'h11);
        cyc();
        chk("pt_rs_ex", 32'(a_rs[0]), 32'd3);
        chk("pt_rt_ex", 32'(a_rt[0]), 32'd4);
        chk("pt_rd_ex", 32'(a_rd[0]), 32'd5);
        chk("pt_rd1_ex", a_rd1[0], 32'h11);
        chk("pt_ctrl_ex", 32'(a_ctrl[0]), 32'h041);
        chk("pt_pc_write", 32'(a_pcw[0]), 32'h1);

        // Load-use on rs
        set_id(LW, 5'd1, 5'd8, 5'd0, 1'b0, 32'h40);
        cyc();
        set_id(ALU, 5'd8, 5'd9, 5'd10, 1'b1, 32'h88);
        #1;
        chk("lu_stall", 32'(a_stall[0]), 32'h1);
        chk("lu_pc_write", 32'(a_pcw[0]), 32'h0);
        chk("lu_if_id_write", 32'(a_ifw[0]), 32'h0);
        cyc();
        chk("lu_bubble_ctrl", 32'(a_ctrl[0]), 32'h0);
        chk("lu_count", 32'(a_cnt[0]), 32'd1);
        chk("lu_stall_done", 32'(a_stall[0]), 32'h0);
        cyc();
        chk("lu_held_rs_ex", 32'(a_rs[0]), 32'd8);
        cyc();
        nops(3);

        // No false stalls: load to r0, and rt match with rt unused
        set_id(LW, 5'd0, 5'd0, 5'd0, 1'b0, 32'h50);
        cyc();
        set_id(ALU, 5'd0, 5'd0, 5'd2, 1'b1, 32'h60);
        #1;
        chk("nf_r0_stall", 32'(a_stall[0]), 32'h0);
        cyc();
        set_id(LW, 5'd0, 5'd7, 5'd0, 1'b0, 32'h70);
        cyc();
        set_id(ALU, 5'd1, 5'd7, 5'd3, 1'b0, 32'h80);
        #1;
        chk("nf_urt0_stall", 32'(a_stall[0]), 32'h0);
        uses_rt_id = 1'b1;
        #1;
        chk("nf_urt1_stall", 32'(a_stall[0]), 32'h1);
        cyc();
        nops(3);

        // Flush beats a live hazard
        set_id(LW, 5'd0, 5'd8, 5'd0, 1'b0, 32'h90);
        cyc();
        set_id(ALU, 5'd8, 5'd2, 5'd3, 1'b1, 32'hA0);
        flush = 1'b1;
        #1;
        chk("fl_stall", 32'(a_stall[0]), 32'h0);
        chk("fl_pc_write", 32'(a_pcw[0]), 32'h1);
        cyc();
        flush = 1'b0;
        chk("fl_bubble_ctrl", 32'(a_ctrl[0]), 32'h0);
        chk("fl_bubble_rs", 32'(a_rs[0]), 32'h0);
        chk("fl_count", 32'(a_cnt[0]), 32'd2);
        nops(3);

        // Three-bubble stall on instance 1
        set_id(LW, 5'd0, 5'd8, 5'd0, 1'b0, 32'hB0);
        cyc();
        set_id(ALU, 5'd8, 5'd2, 5'd3, 1'b1, 32'hC0);
        #1;
        chk("ms_stall_c0", 32'(a_stall[1]), 32'h1);
        for (int i = 1; i <= 2; i++) begin
            cyc();
            chk($sformatf("ms_bubble%0d", i), 32'(a_ctrl[1]), 32'h0);
            chk($sformatf("ms_pc_write_c%0d", i), 32'(a_pcw[1]), 32'h0);
        end
        cyc();
        chk("ms_bubble3", 32'(a_ctrl[1]), 32'h0);
        chk("ms_stall_end", 32'(a_stall[1]), 32'h0);
        cyc();
        chk("ms_held_rs_ex", 32'(a_rs[1]), 32'd8);
        nops(3);

        // Reset during the second stall cycle
        set_id(LW, 5'd0, 5'd8, 5'd0, 1'b0, 32'hD0);
        cyc();
        set_id(ALU, 5'd8, 5'd2, 5'd3, 1'b1, 32'hE0);
        cyc();
        reset = 1'b1;
        #1;
        chk("mr_in_stall", 32'(a_stall[1]), 32'h1);
        cyc();
        reset = 1'b0;
        nops(0);
        #1;
        chk("mr_ctrl_ex", 32'(a_ctrl[1]), 32'h0);
        chk("mr_rd1_ex", a_rd1[1], 32'h0);
        chk("mr_count", 32'(a_cnt[1]), 32'h0);
        chk("mr_pc_write", 32'(a_pcw[1]), 32'h1);
        cyc();

        // Saturation: a lw reading its own rt alternates load / bubble, 20 hazards in 40 edges
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        set_id(LW, 5'd8, 5'd8, 5'd0, 1'b1, 32'hF0);
        repeat (40) cyc();
        chk("sat_count_4bit", 32'(a_cnt[2]), 32'hF);
        chk("sat_count_16bit", 32'(a_cnt[0]), 32'd20);
        nops(4);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
